// File: rtl/stream_burst_writer.sv
// stream_burst_writer: drains a first-word-fall-through FIFO into a frame buffer
// with fixed 16-beat x 8-byte INCR AXI write bursts, one burst outstanding.
// The frame offset advances by 128 per completed burst and wraps at FRAME_BYTES.
// Optional macro STREAM_WRITER_ERRCNT_EN adds a saturating count of error responses.
module stream_burst_writer #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'd614400
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] fifo_data,
  input  logic        fifo_valid,
  output logic        fifo_rd,
  input  logic        burst_valid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state_q, state_d;
  logic        running_q, running_d;
  logic [31:0] offset_q, offset_d;
  logic [3:0]  beat_q, beat_d;
  logic        awvalid_q, awvalid_d;
  logic        bready_q, bready_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;

  logic        in_data;
  logic        w_hs;
  logic        b_hs;
  logic [31:0] offset_inc;

  // Fixed burst shape: 16 beats of 8 bytes, incrementing, all bytes enabled.
  assign awlen   = 4'd15;
  assign awsize  = 3'd3;
  assign awburst = 2'b01;
  assign wstrb   = 8'hFF;

  // Write channel is a zero-latency pass-through of the FIFO head while in DATA.
  assign in_data = (state_q == DATA);
  assign wvalid  = in_data && fifo_valid;
  assign wdata   = in_data ? fifo_data : 64'd0;
  assign fifo_rd = wvalid && wready;
  assign wlast   = in_data && (beat_q == 4'd15);
  assign w_hs    = fifo_rd;
  assign b_hs    = bvalid && bready_q;

  assign awaddr     = BASE_ADDR + offset_q;
  assign awvalid    = awvalid_q;
  assign bready     = bready_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

  assign offset_inc = offset_q + 32'd128;

  // Next-state and registered-output computation for the burst FSM.
  always_comb begin
    state_d      = state_q;
    running_d    = running_q | start;
    offset_d     = offset_q;
    beat_d       = beat_q;
    awvalid_d    = awvalid_q;
    bready_d     = bready_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (running_q && burst_valid) begin
          state_d   = ADDR;
          awvalid_d = 1'b1;
        end
      end
      ADDR: begin
        if (awvalid_q && awready) begin
          state_d   = DATA;
          awvalid_d = 1'b0;
          beat_d    = 4'd0;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == 4'd15) begin
            state_d  = RESP;
            bready_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          state_d  = IDLE;
          bready_d = 1'b0;
          if (offset_inc == FRAME_BYTES) begin
            offset_d     = 32'd0;
            frame_done_d = 1'b1;
          end else begin
            offset_d = offset_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      running_q    <= 1'b0;
      offset_q     <= 32'd0;
      beat_q       <= 4'd0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      running_q    <= running_d;
      offset_q     <= offset_d;
      beat_q       <= beat_d;
      awvalid_q    <= awvalid_d;
      bready_q     <= bready_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef STREAM_WRITER_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of non-OKAY write responses.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (b_hs && (bresp != 2'b00) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  // Response code is ignored when error counting is compiled out.
  logic unused_bresp;
  assign unused_bresp = ^bresp;
  assign err_cnt      = 16'd0;
`endif

endmodule

// File: tb/tb_stream_burst_writer.sv
// Directed bench for stream_burst_writer with a small FWFT FIFO model.
// The DUT is built with FRAME_BYTES=256 so the frame wraps every two bursts.
module tb_stream_burst_writer;

  logic        fclk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_rd;
  logic        burst_valid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        frame_done;
  logic        busy;
  logic [15:0] err_cnt;

  always #5 fclk = ~fclk;

  stream_burst_writer #(
    .BASE_ADDR  (32'h3000_0000),
    .FRAME_BYTES(32'd256)
  ) dut (
    .fclk       (fclk),
    .rst        (rst),
    .start      (start),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_rd    (fifo_rd),
    .burst_valid(burst_valid),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awsize     (awsize),
    .awburst    (awburst),
    .awvalid    (awvalid),
    .awready    (awready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .wlast      (wlast),
    .wvalid     (wvalid),
    .wready     (wready),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .frame_done (frame_done),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] fifo_q[$];
  logic [31:0] addr_log[$];
  logic [63:0] exp_data;
  int          n_beats;
  int          n_rd;
  int          n_fd = 0;
  int          n_b = 0;
  bit          saw_awvalid;
  bit          saw_busy;
  bit          stall_fifo;
  bit          pop_pend;
  int          exp_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_valid  = (fifo_q.size() > 0) && !stall_fifo;
    fifo_data   = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
    burst_valid = (fifo_q.size() >= 16);
  endtask

  task automatic preload(input logic [63:0] base);
    fifo_q.delete();
    for (int i = 0; i < 16; i++) fifo_q.push_back(base + 64'(i));
    exp_data = base;
    n_beats  = 0;
    n_rd     = 0;
    addr_log.delete();
    drive_fifo();
  endtask

  // One clock: observe on the falling edge, update the FIFO model after the rising edge.
  task automatic cycle();
    logic [63:0] tmp;
    @(negedge fclk);
    if (awvalid) saw_awvalid = 1'b1;
    if (busy) saw_busy = 1'b1;
    if (awvalid && awready) addr_log.push_back(awaddr);
    if (fifo_rd) n_rd++;
    if (wvalid && wready) begin
      chk("wdata", wdata, exp_data);
      chk("wlast", 64'(wlast), 64'(n_beats == 15));
      exp_data = exp_data + 64'd1;
      n_beats++;
    end
    if (frame_done) n_fd++;
    if (bvalid && bready) n_b++;
    pop_pend = fifo_rd;
    @(posedge fclk);
    #1;
    if (pop_pend && fifo_q.size() > 0) tmp = fifo_q.pop_front();
    drive_fifo();
  endtask

  // Run until one write response is taken; mode 1 throttles wready and stalls the FIFO.
  task automatic run_burst(input int mode, input logic [1:0] resp);
    int cyc = 0;
    int nb0 = n_b;
    bresp = resp;
    while (n_b == nb0 && cyc < 300) begin
      if (mode != 0) begin
        wready     = (cyc % 2 == 0);
        stall_fifo = (cyc >= 8 && cyc < 11);
        drive_fifo();
      end
      cycle();
      cyc++;
    end
    chk("burst_resp_seen", 64'(n_b - nb0), 64'd1);
    wready     = 1'b1;
    stall_fifo = 1'b0;
    bresp      = 2'b00;
    drive_fifo();
    cycle();
    $display("burst addr=%h beats=%0d pops=%0d frame_done_total=%0d err_cnt=%0d",
             (addr_log.size() > 0) ? addr_log[0] : 32'h0, n_beats, n_rd, n_fd, err_cnt);
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] exp);
    chk({tag, "_aw_count"}, 64'(addr_log.size()), 64'd1);
    chk(tag, 64'((addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF), 64'(exp));
  endtask

  initial begin
`ifdef STREAM_WRITER_ERRCNT_EN
    exp_err = 2;
`else
    exp_err = 0;
`endif
    rst        = 1'b1;
    start      = 1'b0;
    awready    = 1'b1;
    wready     = 1'b1;
    bvalid     = 1'b1;
    bresp      = 2'b00;
    stall_fifo = 1'b0;
    pop_pend   = 1'b0;
    n_beats    = 0;
    n_rd       = 0;
    exp_data   = 64'd0;
    drive_fifo();
    repeat (3) @(posedge fclk);
    #1;
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("rst_wlast", 64'(wlast), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("awlen", 64'(awlen), 64'd15);
    chk("awsize", 64'(awsize), 64'd3);
    chk("awburst", 64'(awburst), 64'd1);
    chk("wstrb", 64'(wstrb), 64'hFF);
    rst = 1'b0;

    // No start: a full FIFO must not trigger a burst.
    preload(64'd0);
    saw_awvalid = 1'b0;
    saw_busy    = 1'b0;
    repeat (100) cycle();
    chk("nostart_awvalid", 64'(saw_awvalid), 64'd0);
    chk("nostart_busy", 64'(saw_busy), 64'd0);

    // Burst 1: all ready, data 0..15.
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_burst(0, 2'b00);
    chk_addr("b1_addr", 32'h3000_0000);
    chk("b1_beats", 64'(n_beats), 64'd16);
    chk("b1_pops", 64'(n_rd), 64'd16);
    chk("b1_frame_done", 64'(n_fd), 64'd0);

    // Burst 2: throttled wready plus FIFO stall, error response, closes the frame.
    preload(64'd16);
    run_burst(1, 2'b10);
    chk_addr("b2_addr", 32'h3000_0080);
    chk("b2_beats", 64'(n_beats), 64'd16);
    chk("b2_pops", 64'(n_rd), 64'd16);
    chk("b2_frame_done", 64'(n_fd), 64'd1);

    // Burst 3: wrapped address, second error response; start while running is harmless.
    preload(64'd32);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_burst(0, 2'b10);
    chk_addr("b3_addr", 32'h3000_0000);
    chk("b3_beats", 64'(n_beats), 64'd16);
    chk("b3_frame_done", 64'(n_fd), 64'd1);
    chk("err_cnt", 64'(err_cnt), 64'(exp_err));

    // Burst 4: reset once seven beats have been accepted.
    preload(64'd64);
    begin
      int budget = 0;
      while (n_beats < 7 && budget < 200) begin
        cycle();
        budget++;
      end
    end
    chk("b4_beats_before_rst", 64'(n_beats), 64'd7);
    chk("b4_addr", 64'((addr_log.size() > 0) ? addr_log[0] : 32'h0), 64'h3000_0080);
    chk("b4_wvalid_before_rst", 64'(wvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_wvalid", 64'(wvalid), 64'd0);
    chk("midrst_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("midrst_wlast", 64'(wlast), 64'd0);
    chk("midrst_awvalid", 64'(awvalid), 64'd0);
    chk("midrst_bready", 64'(bready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_frame_done", 64'(frame_done), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    chk("midrst_awaddr", 64'(awaddr), 64'h3000_0000);
    pop_pend = 1'b0;
    repeat (2) @(posedge fclk);
    #1;
    rst = 1'b0;

    // After reset: idle until a fresh start, then burst from the base address.
    preload(64'd100);
    saw_awvalid = 1'b0;
    repeat (10) cycle();
    chk("postrst_nostart_awvalid", 64'(saw_awvalid), 64'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_burst(0, 2'b00);
    chk_addr("b5_addr", 32'h3000_0000);
    chk("b5_beats", 64'(n_beats), 64'd16);
    chk("b5_pops", 64'(n_rd), 64'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_burst_writer.md
STREAM_BURST_WRITER -- requirements
Module: stream_burst_writer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000: byte address of frame buffer start; SHALL be 128-byte aligned.
REQ-002 Parameter FRAME_BYTES, default 32'd614400: frame size in bytes; SHALL be a nonzero multiple of 128.
REQ-003 Ports SHALL be (name  direction  width  meaning); all signals SHALL be synchronous to fclk:
- fclk  in  1  sole clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; arms the writer
- fifo_data  in  64  first-word-fall-through FIFO head word
- fifo_valid  in  1  FIFO not empty
- fifo_rd  out  1  pop FIFO head
- burst_valid  in  1  FIFO holds >= 16 words
- awaddr  out  32  burst address
- awlen  out  4  constant 4'd15
- awsize  out  3  constant 3'd3
- awburst  out  2  constant 2'b01 (INCR)
- awvalid  out  1  address valid
- awready  in  1  address accepted
- wdata  out  64  write beat
- wstrb  out  8  constant 8'hFF
- wlast  out  1  final beat
- wvalid  out  1  beat valid
- wready  in  1  beat accepted
- bresp  in  2  write response
- bvalid  in  1  response valid
- bready  out  1  response accept
- frame_done  out  1  one-cycle pulse at frame end
- busy  out  1  burst in flight (state != IDLE)
- err_cnt  out  16  error count (see Configuration)

Function
REQ-004 Writer SHALL hold a running flag: set by start, cleared only by rst; start while running SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, ADDR, DATA, RESP; one outstanding burst maximum.
REQ-006 IDLE->ADDR SHALL occur on the cycle running && burst_valid; awvalid SHALL be registered high from the next cycle.
REQ-007 In ADDR, awvalid and awaddr SHALL hold stable until awready; on awvalid && awready the FSM SHALL go to DATA with beat counter = 0.
REQ-008 In DATA: wvalid = fifo_valid; wdata = fifo_data (combinational, zero latency); fifo_rd = wvalid && wready.
REQ-009 Beat counter (4-bit) SHALL increment per wvalid && wready handshake; wlast SHALL equal (counter == 15) while in DATA.
REQ-010 Handshake with wlast SHALL move the FSM to RESP; exactly 16 FIFO pops per burst.
REQ-011 In RESP, bready SHALL be 1; on bvalid the FSM SHALL return to IDLE and the address offset SHALL advance by 128.
REQ-012 When the advanced offset equals FRAME_BYTES, the offset SHALL wrap to 0 and frame_done SHALL pulse for exactly that cycle.
REQ-013 awaddr SHALL equal BASE_ADDR + offset; offset arithmetic SHALL be 32-bit unsigned.
REQ-014 Burst completion and burst_valid in the same cycle SHALL NOT start a new burst until the FSM is back in IDLE (one idle cycle minimum between bursts).
REQ-015 fifo_valid low mid-burst SHALL stall the beat (wvalid low) without aborting; the counter holds.
REQ-016 Outside DATA, fifo_rd, wvalid and wlast SHALL be 0; outside ADDR, awvalid SHALL be 0; outside RESP, bready SHALL be 0.

Reset
REQ-017 rst SHALL asynchronously force: state IDLE, running 0, offset 0, beat counter 0, awvalid/wvalid/wlast/bready/fifo_rd/frame_done/busy 0, err_cnt 0.
REQ-018 rst mid-burst SHALL abandon the burst immediately; no completion is attempted (system-wide reset assumed by the bus).
REQ-019 After rst release, no burst SHALL start before a new start pulse.

Configuration
REQ-020 Macro STREAM_WRITER_ERRCNT_EN defined: err_cnt SHALL increment (saturating at 16'hFFFF) on each bvalid && bready with bresp != 2'b00.
REQ-021 Macro undefined: err_cnt SHALL be tied to 0 and no counter logic instantiated; all other behaviour identical.

Verification
REQ-022 Reset, no start, burst_valid=1 for 100 cycles -> awvalid never asserts, busy=0.
REQ-023 start, FIFO preloaded 16 words 0..15, awready/wready/bvalid always 1 -> awaddr=32'h3000_0000, 16 beats wdata 0..15, wlast only on beat 15, 16 fifo_rd pulses, next awaddr=32'h3000_0080.
REQ-024 FRAME_BYTES=256, 3 bursts -> addresses 3000_0000, 3000_0080, 3000_0000; frame_done pulses once, after burst 2's bvalid.
REQ-025 wready toggled 1/0 and fifo_valid dropped for 3 cycles mid-burst -> no beat lost or duplicated; wdata order preserved.
REQ-026 Macro defined, bresp=2'b10 on 2 bursts -> err_cnt=2; macro undefined -> err_cnt=0.
REQ-027 rst asserted in DATA at beat 7 -> all outputs 0 same cycle; after release + start, first awaddr=BASE_ADDR.
